// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pkg
//  Purpose  : Shared types and constants for the SRAM port arbiter.
//             - rd_owner_t : which requester owns the outstanding read
//             - prio_t     : round-robin priority pointer encoding
//             - PRIO_RESET : pointer value after reset (data side first)
//  Revision : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        I    = 2'd1,
        D    = 2'd2
    } rd_owner_t;

    typedef enum logic {
        PRIO_I = 1'b0,
        PRIO_D = 1'b1
    } prio_t;

    localparam prio_t PRIO_RESET = PRIO_D;

    localparam int unsigned PERF_CNT_W = 32;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_rr2.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_rr2
//  Purpose  : Two-way round-robin picker. Grant is combinational from the
//             request vector; the priority pointer flop moves to the losing
//             requester after every contested cycle.
//  Ports    : clk      - clock, rising edge
//             rst_n    - asynchronous active-low reset
//             i_req[1:0] - requests (bit 0 = instruction, bit 1 = data)
//             o_gnt[1:0] - grants, one-hot or zero
//  Revision : 1.0  initial release
// ============================================================================
module sram_arb_rr2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    prio_t r_prio;
    prio_t w_prio_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_RESET;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    always_comb begin
        o_gnt      = 2'b00;
        w_prio_nxt = r_prio;
        case (i_req)
            2'b01: o_gnt = 2'b01;
            2'b10: o_gnt = 2'b10;
            2'b11: begin
                // Contested: serve the pointer side, hand priority to the loser.
                if (r_prio == PRIO_D) begin
                    o_gnt      = 2'b10;
                    w_prio_nxt = PRIO_I;
                end else begin
                    o_gnt      = 2'b01;
                    w_prio_nxt = PRIO_D;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

endmodule : sram_arb_rr2
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Shares one synchronous single-port SRAM between an instruction
//             fetch port (read-only) and a data port (read/write). One access
//             per cycle, round-robin on conflict, read data returned one cycle
//             after the grant with a per-requester valid strobe.
//  Ports    : clk, resetn (async active-low)
//             i_req/i_addr -> i_gnt, i_rvalid, i_rdata      instruction side
//             d_req/d_wen/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata  data side
//             sram_en/sram_wen/sram_addr/sram_wdata -> SRAM, sram_rdata <- SRAM
//  Options  : SRAM_ARB_PERF_EN adds perf_i_grants, perf_d_grants and
//             perf_conflicts (32-bit saturating event counters).
//  Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,

    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_i_grants,
    output logic [PERF_CNT_W-1:0] perf_d_grants,
    output logic [PERF_CNT_W-1:0] perf_conflicts
`endif
);

    localparam int BE_W = DATA_W / 8;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_d_read;
    rd_owner_t  r_rd_owner;

    // Requests are masked while reset is held so no grant or SRAM enable
    // can leak out combinationally during reset.
    assign w_req = {d_req & resetn, i_req & resetn};

    sram_arb_rr2 u_rr2 (
        .clk   (clk),
        .rst_n (resetn),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign i_gnt    = w_gnt[0];
    assign d_gnt    = w_gnt[1];
    assign w_d_read = d_gnt && (d_wen == '0);

    // SRAM drive: granted side's payload, zero when idle.
    assign sram_en    = i_gnt | d_gnt;
    assign sram_wen   = d_gnt ? d_wen : {BE_W{1'b0}};
    assign sram_addr  = d_gnt ? d_addr  : (i_gnt ? i_addr : {ADDR_W{1'b0}});
    assign sram_wdata = d_gnt ? d_wdata : {DATA_W{1'b0}};

    // Owner of the read whose data appears on sram_rdata next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_owner <= NONE;
        end else if (w_d_read) begin
            r_rd_owner <= D;
        end else if (i_gnt) begin
            r_rd_owner <= I;
        end else begin
            r_rd_owner <= NONE;
        end
    end

    assign i_rvalid = (r_rd_owner == I);
    assign d_rvalid = (r_rd_owner == D);
    assign i_rdata  = sram_rdata;
    assign d_rdata  = sram_rdata;

`ifdef SRAM_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] r_perf_i;
    logic [PERF_CNT_W-1:0] r_perf_d;
    logic [PERF_CNT_W-1:0] r_perf_c;

    // Saturating counters: stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_i <= '0;
            r_perf_d <= '0;
            r_perf_c <= '0;
        end else begin
            if (i_gnt && (r_perf_i != '1)) begin
                r_perf_i <= r_perf_i + 1'b1;
            end
            if (d_gnt && (r_perf_d != '1)) begin
                r_perf_d <= r_perf_d + 1'b1;
            end
            if (i_req && d_req && (r_perf_c != '1)) begin
                r_perf_c <= r_perf_c + 1'b1;
            end
        end
    end

    assign perf_i_grants  = r_perf_i;
    assign perf_d_grants  = r_perf_d;
    assign perf_conflicts = r_perf_c;
`endif

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Self-checking bench for sram_port_arbiter with a behavioural
//             SRAM, a reference arbiter and a read-return scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [3:0]  d_wen = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_wen      (d_wen),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
`ifdef SRAM_ARB_PERF_EN
        ,
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- behavioural SRAM ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
    endfunction

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen != 4'b0000) begin
                logic [31:0] w;
                w = mem_rd(sram_addr);
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                mem[sram_addr] = w;
            end else begin
                sram_rdata <= mem_rd(sram_addr);
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int          due;
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    logic m_prio_d = 1'b1;
    int   i_wait = 0, d_wait = 0;

    always @(negedge clk) begin
        logic gi, gd, ei, ed;
        logic [31:0] edata;
        exp_t e;
        cyc++;
        if (!resetn) begin
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_sram_en", sram_en, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            q.delete();
            m_prio_d = 1'b1;
            i_wait = 0;
            d_wait = 0;
        end else begin
            ei = 0; ed = 0; edata = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                ei = !e.is_d;
                ed = e.is_d;
                edata = e.data;
            end
            chk("i_rvalid", i_rvalid, ei);
            chk("d_rvalid", d_rvalid, ed);
            if (ei) chk("i_rdata", i_rdata, edata);
            if (ed) chk("d_rdata", d_rdata, edata);

            gi = i_req && (!d_req || !m_prio_d);
            gd = d_req && (!i_req || m_prio_d);
            chk("i_gnt", i_gnt, gi);
            chk("d_gnt", d_gnt, gd);
            chk("sram_en", sram_en, gi || gd);
            chk("sram_addr", sram_addr, gd ? d_addr : (gi ? i_addr : 32'h0));
            chk("sram_wdata", sram_wdata, gd ? d_wdata : 32'h0);
            chk("sram_wen", sram_wen, gd ? d_wen : 4'h0);
            if (i_req && d_req) m_prio_d = !gd;

            if (gi) q.push_back('{due: cyc + 1, is_d: 1'b0, data: mem_rd(i_addr)});
            if (gd && d_wen == 4'h0) q.push_back('{due: cyc + 1, is_d: 1'b1, data: mem_rd(d_addr)});

            i_wait = (i_req && !i_gnt) ? i_wait + 1 : 0;
            d_wait = (d_req && !d_gnt) ? d_wait + 1 : 0;
            if (i_wait > 0) chk("i_starve", i_wait <= 1, 1);
            if (d_wait > 0) chk("d_starve", d_wait <= 1, 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 0; d_req = 0; d_wen = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi_prev, gd_prev;
        mem[32'h100] = 32'hDEADBEEF;

        // Contested from reset: D, I, D, I.
        do_reset();
        i_req = 1; i_addr = 32'h1000;
        d_req = 1; d_addr = 32'h2000; d_wen = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_d_gnt", d_gnt, (k % 2) == 0);
            chk("alt_i_gnt", i_gnt, (k % 2) == 1);
            tick();
        end
        idle();
`ifdef SRAM_ARB_PERF_EN
        chk("perf_i", perf_i_grants, 2);
        chk("perf_d", perf_d_grants, 2);
        chk("perf_c", perf_conflicts, 4);
`endif
        tick();

        // Single data read after reset.
        do_reset();
        d_req = 1; d_wen = '0; d_addr = 32'h100;
        @(negedge clk);
        chk("rd_d_gnt", d_gnt, 1);
        tick();
        idle();
        @(negedge clk);
        chk("rd_d_rvalid", d_rvalid, 1);
        chk("rd_d_rdata", d_rdata, 32'hDEADBEEF);
        chk("rd_i_rvalid", i_rvalid, 0);
        tick();

        // Partial write, then read it back.
        d_req = 1; d_wen = 4'b0011; d_addr = 32'h20; d_wdata = 32'h12345678;
        @(negedge clk);
        chk("wr_sram_wen", sram_wen, 4'b0011);
        chk("wr_sram_wdata", sram_wdata, 32'h12345678);
        tick();
        d_wen = '0; d_wdata = '0;
        @(negedge clk);
        chk("wr_no_rvalid", d_rvalid, 0);
        tick();
        idle();
        tick();

        // Instruction stream alone.
        i_req = 1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 32'hBFC0_0000 + 32'(4 * k);
            @(negedge clk);
            chk("ifetch_gnt", i_gnt, 1);
            tick();
        end
        // Pointer untouched by uncontested grants: data still wins.
        d_req = 1; d_addr = 32'h24; i_addr = 32'hBFC0_000C;
        @(negedge clk);
        chk("prio_kept_d_gnt", d_gnt, 1);
        tick();
        idle();
        tick();

        // Reset lands while a read is outstanding.
        i_req = 1; i_addr = 32'h40;
        @(negedge clk);
        #2;
        resetn = 0;
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1;
        @(negedge clk);
        chk("mid_rst_i_rvalid", i_rvalid, 0);
        chk("mid_rst_d_rvalid", d_rvalid, 0);
        tick();
        i_req = 1; d_req = 1; i_addr = 32'h44; d_addr = 32'h48;
        @(negedge clk);
        chk("post_rst_d_first", d_gnt, 1);
        tick();
        idle();
        tick();

        // Random protocol-respecting traffic.
        gi_prev = 0; gd_prev = 0;
        for (int n = 0; n < 80; n++) begin
            if (!i_req || gi_prev) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = 32'h300 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            end
            if (!d_req || gd_prev) begin
                d_req   = 1'($urandom_range(0, 1));
                d_addr  = 32'h300 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
                d_wdata = $urandom;
                d_wen   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            @(negedge clk);
            gi_prev = i_gnt;
            gd_prev = d_gnt;
            tick();
        end
        idle();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
